// File: rtl/rsa_stream_ctrl_pkg.sv
// rsa_stream_ctrl_pkg: shared widths, FSM encoding and error result for the RSA stream controller
package rsa_stream_ctrl_pkg;
  localparam int DEF_WIDTH  = 32;
  localparam int DEF_TAG_W  = 8;
  localparam int ERR_RESULT = 0;
  typedef enum logic [2:0] {
    ST_DRAIN  = 3'd0,
    ST_NOKEY  = 3'd1,
    ST_READY  = 3'd2,
    ST_LAUNCH = 3'd3,
    ST_SETTLE = 3'd4,
    ST_WAIT   = 3'd5,
    ST_OUT    = 3'd6
  } state_t;
endpackage

// File: rtl/rsa_stream_ctrl.sv
// rsa_stream_ctrl: holds an RSA key and feeds message words one at a time to a modexp core
module rsa_stream_ctrl
  import rsa_stream_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int TAG_W = DEF_TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_load,
  input  logic [WIDTH-1:0] key_exp,
  input  logic [WIDTH-1:0] key_mod,
  output logic             key_ready,
  output logic             key_err,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err,
  output logic [WIDTH-1:0] me_base,
  output logic [WIDTH-1:0] me_exponent,
  output logic [WIDTH-1:0] me_modulo,
  output logic             me_valid,
  input  logic             me_ready,
  input  logic [WIDTH-1:0] me_result
);
  state_t state, state_nx;
  logic key_ok, idle, accept, key_good, word_bad;
  logic [WIDTH-1:0] base_r, exp_r, mod_r;
  logic [TAG_W-1:0] tag_cnt;
  assign me_base     = base_r;
  assign me_exponent = exp_r;
  assign me_modulo   = mod_r;
  assign out_tag     = tag_cnt;
  always_comb begin
    idle      = state == ST_NOKEY || state == ST_READY;
    key_ready = idle;
    in_ready  = idle && !key_load;
    accept    = in_ready && in_valid;
    key_good  = key_mod >= WIDTH'(2);
    word_bad  = !key_ok || in_data >= mod_r;
    me_valid  = state == ST_LAUNCH;
    out_valid = state == ST_OUT;
    state_nx  = state;
    case (state)
      ST_DRAIN:           state_nx = me_ready ? (key_ok ? ST_READY : ST_NOKEY) : ST_DRAIN;
      ST_NOKEY, ST_READY: state_nx = key_load ? (key_good ? ST_READY : ST_NOKEY)
                                   : accept ? (word_bad ? ST_OUT : ST_LAUNCH) : state;
      ST_LAUNCH:          state_nx = ST_SETTLE;
      // the core still shows its old ready here, so it is not trusted until WAIT
      ST_SETTLE:          state_nx = ST_WAIT;
      ST_WAIT:            state_nx = me_ready ? ST_OUT : ST_WAIT;
      ST_OUT:             state_nx = out_ready ? (key_ok ? ST_READY : ST_NOKEY) : ST_OUT;
      default:            state_nx = ST_DRAIN;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_DRAIN;
      key_ok   <= 1'b0;
      key_err  <= 1'b0;
      exp_r    <= '0;
      mod_r    <= '0;
      base_r   <= '0;
      tag_cnt  <= '0;
      out_data <= '0;
      out_err  <= 1'b0;
    end else begin
      state <= state_nx;
      if (idle && key_load) begin
        key_ok  <= key_good;
        key_err <= !key_good;
        if (key_good) begin
          exp_r <= key_exp;
          mod_r <= key_mod;
        end
      end
      if (accept) begin
        base_r   <= in_data;
        out_data <= WIDTH'(ERR_RESULT);
        out_err  <= word_bad;
      end
      if (state == ST_WAIT && me_ready) begin
        out_data <= me_result;
        out_err  <= 1'b0;
      end
      if (state == ST_OUT && out_ready) tag_cnt <= tag_cnt + TAG_W'(1);
    end
  end
endmodule

// File: tb/tb_rsa_stream_ctrl.sv
// tb_rsa_stream_ctrl: directed vectors for rsa_stream_ctrl against a behavioural modexp core
module tb_rsa_stream_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key_load = 1'b0;
  logic [31:0] key_exp = '0, key_mod = '0;
  logic key_ready, key_err;
  logic in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic in_ready, out_valid;
  logic out_ready = 1'b0;
  logic [31:0] out_data;
  logic [7:0] out_tag;
  logic out_err;
  logic [31:0] me_base, me_exponent, me_modulo;
  logic me_valid;
  logic me_ready = 1'b1;
  logic [31:0] me_result = '0;
  int core_cnt = 0;
  int n_launch = 0;
  int n_tests = 0, n_fail = 0;
  logic [7:0] exp_tag;

  always #5 clk = ~clk;

  rsa_stream_ctrl dut (
    .clk(clk), .rst(rst), .key_load(key_load), .key_exp(key_exp), .key_mod(key_mod),
    .key_ready(key_ready), .key_err(key_err), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_err(out_err), .me_base(me_base), .me_exponent(me_exponent),
    .me_modulo(me_modulo), .me_valid(me_valid), .me_ready(me_ready), .me_result(me_result)
  );

  function automatic logic [31:0] mexp(input logic [31:0] b, input logic [31:0] e, input logic [31:0] n);
    logic [63:0] r, bb;
    r = 64'd1;
    bb = {32'd0, b} % {32'd0, n};
    for (int i = 0; i < 32; i++) begin
      if (e[i]) r = (r * bb) % {32'd0, n};
      bb = (bb * bb) % {32'd0, n};
    end
    return r[31:0];
  endfunction

  function automatic int bitlen(input logic [31:0] e);
    int l;
    l = 1;
    for (int i = 0; i < 32; i++) if (e[i]) l = i + 1;
    return l;
  endfunction

  // core has no reset: it keeps counting through rst, busy for bitlen(e) cycles after acceptance
  always @(posedge clk) begin
    if (me_valid) n_launch <= n_launch + 1;
    if (me_valid && me_ready && core_cnt == 0) begin
      core_cnt  <= bitlen(me_exponent);
      me_result <= mexp(me_base, me_exponent, me_modulo);
    end else begin
      if (core_cnt != 0) core_cnt <= core_cnt - 1;
      me_ready <= core_cnt <= 1;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic load_key(input logic [31:0] e, input logic [31:0] n);
    int t;
    t = 0;
    while (!key_ready && t < 200) begin tick(); t++; end
    if (!key_ready) check("load_key_timeout", 0, 1);
    key_exp = e; key_mod = n; key_load = 1'b1;
    tick();
    key_load = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] m);
    int t;
    t = 0;
    in_data = m; in_valid = 1'b1;
    #1;
    while (!in_ready && t < 200) begin tick(); t++; end
    if (!in_ready) check("send_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic get_out(output logic [31:0] d, output logic [7:0] tg, output logic er);
    int t;
    t = 0;
    while (!out_valid && t < 500) begin tick(); t++; end
    d = out_data; tg = out_tag; er = out_err;
    if (!out_valid) begin
      check("out_timeout", 0, 1);
    end else begin
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      exp_tag++;
    end
  endtask

  typedef struct {
    logic ld;
    logic [31:0] e, n, m, data;
    logic [7:0] tag;
    logic err, kerr;
    int launches;
  } vec_t;
  vec_t v[6];

  initial begin
    logic [31:0] d, d0;
    logic [7:0] tg, tg0;
    logic er, er0, stable, rdy_low;
    int l0, t;
    v[0] = '{1'b1, 32'd17,   32'd3233, 32'd65,   32'd2790, 8'd0, 1'b0, 1'b0, 1};
    v[1] = '{1'b1, 32'd2753, 32'd3233, 32'd2790, 32'd65,   8'd1, 1'b0, 1'b0, 1};
    v[2] = '{1'b1, 32'd0,    32'd3233, 32'd5,    32'd1,    8'd2, 1'b0, 1'b0, 1};
    v[3] = '{1'b0, 32'd0,    32'd0,    32'd3233, 32'd0,    8'd3, 1'b1, 1'b0, 0};
    v[4] = '{1'b1, 32'd17,   32'd1,    32'd5,    32'd0,    8'd4, 1'b1, 1'b1, 0};
    v[5] = '{1'b1, 32'd17,   32'd3233, 32'd65,   32'd2790, 8'd5, 1'b0, 1'b0, 1};
    exp_tag = 8'd0;
    tick(); tick();
    check("rst_key_ready", {63'd0, key_ready}, 0);
    check("rst_in_ready", {63'd0, in_ready}, 0);
    check("rst_out_valid", {63'd0, out_valid}, 0);
    check("rst_out_data", {32'd0, out_data}, 0);
    check("rst_out_tag", {56'd0, out_tag}, 0);
    check("rst_out_err", {63'd0, out_err}, 0);
    check("rst_key_err", {63'd0, key_err}, 0);
    check("rst_me_valid", {63'd0, me_valid}, 0);
    rst = 1'b0;
    tick(); tick();
    check("nokey_key_ready", {63'd0, key_ready}, 1);
    for (int i = 0; i < 6; i++) begin
      if (v[i].ld) begin
        load_key(v[i].e, v[i].n);
        check($sformatf("v%0d_key_err", i), {63'd0, key_err}, {63'd0, v[i].kerr});
      end
      l0 = n_launch;
      send_word(v[i].m);
      get_out(d, tg, er);
      check($sformatf("v%0d_data", i), {32'd0, d}, {32'd0, v[i].data});
      check($sformatf("v%0d_tag", i), {56'd0, tg}, {56'd0, v[i].tag});
      check($sformatf("v%0d_err", i), {63'd0, er}, {63'd0, v[i].err});
      check($sformatf("v%0d_launches", i), 64'(n_launch - l0), 64'(v[i].launches));
    end
    send_word(32'd65);
    t = 0;
    while (!out_valid && t < 500) begin tick(); t++; end
    check("stall_valid", {63'd0, out_valid}, 1);
    d0 = out_data; tg0 = out_tag; er0 = out_err;
    stable = 1'b1; rdy_low = 1'b1;
    in_valid = 1'b1; in_data = 32'd65;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!out_valid || out_data !== d0 || out_tag !== tg0 || out_err !== er0) stable = 1'b0;
      if (in_ready) rdy_low = 1'b0;
    end
    in_valid = 1'b0;
    check("stall_stable", {63'd0, stable}, 1);
    check("stall_in_ready_low", {63'd0, rdy_low}, 1);
    check("stall_data", {32'd0, d0}, 2790);
    check("stall_tag", {56'd0, tg0}, 6);
    get_out(d, tg, er);
    send_word(32'd65);
    get_out(d, tg, er);
    check("after_stall_data", {32'd0, d}, 2790);
    check("after_stall_tag", {56'd0, tg}, 7);
    key_exp = 32'd3; key_mod = 32'd3233; key_load = 1'b1;
    in_valid = 1'b1; in_data = 32'd7;
    #1;
    check("collide_in_ready", {63'd0, in_ready}, 0);
    l0 = n_launch;
    tick();
    key_load = 1'b0; in_valid = 1'b0;
    check("collide_key_taken", {32'd0, me_exponent}, 3);
    tick(); tick(); tick();
    check("collide_no_out", {63'd0, out_valid}, 0);
    check("collide_no_launch", 64'(n_launch - l0), 0);
    send_word(32'd7);
    get_out(d, tg, er);
    check("collide_word_data", {32'd0, d}, 343);
    check("collide_word_tag", {56'd0, tg}, 8);
    load_key(32'd2753, 32'd3233);
    send_word(32'd2790);
    t = 0;
    while (me_ready && t < 50) begin tick(); t++; end
    check("midjob_core_busy", {63'd0, me_ready}, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("midjob_drain", {63'd0, key_ready}, 0);
    check("midjob_tag", {56'd0, out_tag}, 0);
    exp_tag = 8'd0;
    t = 0;
    while (!key_ready && t < 100) begin tick(); t++; end
    check("drain_exit", {63'd0, key_ready}, 1);
    check("drain_core_idle", {63'd0, me_ready}, 1);
    load_key(32'd17, 32'd3233);
    send_word(32'd65);
    get_out(d, tg, er);
    check("rerun_data", {32'd0, d}, 2790);
    check("rerun_tag", {56'd0, tg}, 0);
    check("rerun_err", {63'd0, er}, 0);
    load_key(32'd17, 32'd0);
    check("modzero_key_err", {63'd0, key_err}, 1);
    t = 0;
    while (exp_tag != 8'd255 && t < 300) begin
      send_word(32'd9);
      get_out(d, tg, er);
      t++;
    end
    send_word(32'd9);
    get_out(d, tg, er);
    check("wrap_tag_max", {56'd0, tg}, 255);
    check("wrap_err", {63'd0, er}, 1);
    send_word(32'd9);
    get_out(d, tg, er);
    check("wrap_tag_zero", {56'd0, tg}, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
